// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/execute sequencer owning PC and the call/return stack
module pc_sequencer #(
  parameter int PC_W        = 8,
  parameter int OP_W        = 24,
  parameter int STACK_DEPTH = 16,
  parameter int SP_W        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt_req,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [OP_W-1:0]   imem_rdata,
  output logic [OP_W-1:0]   op,
  output logic              op_valid,
  input  logic              is_call,
  input  logic              is_ret,
  input  logic              br_we,
  input  logic [PC_W-1:0]   br_target,
  input  logic              mem_busy,
  output logic [PC_W-1:0]   pc,
  output logic [SP_W:0]     sp,
  output logic [2:0]        state,
  output logic              fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WAIT  = 3'd3,
    S_HALT  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  localparam logic [SP_W:0] SP_FULL = (SP_W+1)'(STACK_DEPTH);

  state_t          st;
  logic [PC_W-1:0] stack_mem [STACK_DEPTH];
  logic [PC_W-1:0] pc_inc;
  logic [SP_W:0]   sp_dec;
  logic [SP_W-1:0] push_idx;
  logic [SP_W-1:0] pop_idx;
  logic            overflow;
  logic            underflow;
  logic            do_call;
  logic            do_ret;

  assign state     = st;
  assign imem_addr = pc;

  // Call wins over return, so a return only underflows when no call is decoded.
  always_comb begin
    pc_inc    = pc + 1'b1;
    sp_dec    = sp - 1'b1;
    push_idx  = sp[SP_W-1:0];
    pop_idx   = sp_dec[SP_W-1:0];
    overflow  = is_call && (sp == SP_FULL);
    underflow = !is_call && is_ret && (sp == '0);
    do_call   = is_call && !overflow;
    do_ret    = !is_call && is_ret && !underflow;
  end

  always_ff @(posedge clk) begin
    if (rst_n && st == S_EXEC && do_call)
      stack_mem[push_idx] <= pc_inc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st       <= S_IDLE;
      pc       <= '0;
      sp       <= '0;
      op       <= '0;
      op_valid <= 1'b0;
      imem_req <= 1'b0;
      fault    <= 1'b0;
    end else begin
      op_valid <= 1'b0;
      case (st)
        S_IDLE: begin
          if (start) begin
            st       <= S_FETCH;
            imem_req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            op       <= imem_rdata;
            op_valid <= 1'b1;
            imem_req <= 1'b0;
            st       <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (overflow || underflow) begin
            fault <= 1'b1;
            st    <= S_FAULT;
          end else begin
            if (do_call) begin
              sp <= sp + 1'b1;
              pc <= br_target;
            end else if (do_ret) begin
              sp <= sp_dec;
              pc <= stack_mem[pop_idx];
            end else if (br_we) begin
              pc <= br_target;
            end else begin
              pc <= pc_inc;
            end
            if (mem_busy) begin
              st <= S_WAIT;
            end else if (halt_req) begin
              st <= S_HALT;
            end else begin
              st       <= S_FETCH;
              imem_req <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (!mem_busy) begin
            if (halt_req) begin
              st <= S_HALT;
            end else begin
              st       <= S_FETCH;
              imem_req <= 1'b1;
            end
          end
        end
        S_HALT: begin
          if (start && !halt_req) begin
            st       <= S_FETCH;
            imem_req <= 1'b1;
          end
        end
        S_FAULT: begin
          st <= S_FAULT;
        end
        default: begin
          st <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, start, halt_req, imem_req, imem_ack, op_valid;
  logic        is_call, is_ret, br_we, mem_busy, fault;
  logic [7:0]  imem_addr, br_target, pc;
  logic [23:0] imem_rdata, op;
  logic [4:0]  sp;
  logic [2:0]  state;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_exec = 0;

  logic [7:0]  addr_q[$];
  logic [23:0] op_q[$];
  logic [7:0]  m_pc;
  logic [4:0]  m_sp;
  logic [7:0]  m_stack [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .op(op), .op_valid(op_valid), .is_call(is_call), .is_ret(is_ret), .br_we(br_we),
    .br_target(br_target), .mem_busy(mem_busy), .pc(pc), .sp(sp), .state(state), .fault(fault)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    is_call = 1'b0; is_ret = 1'b0; br_we = 1'b0; br_target = '0; mem_busy = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    m_pc = '0; m_sp = '0;
  endtask

  task automatic go;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Serve one fetch (ack after dly cycles), play decoder during EXEC, check the result.
  task automatic run_instr(input int dly, input logic [23:0] data, input logic call,
                           input logic ret, input logic br, input logic [7:0] tgt,
                           input logic busy, input logic hlt);
    logic [7:0]  a;
    logic [23:0] o;
    logic [2:0]  exp_st;
    logic        exp_fault;
    halt_req = hlt;
    addr_q.push_back(m_pc);
    op_q.push_back(data);
    tests++;
    if (imem_req !== 1'b1) begin
      fails++; $display("FAIL fetch_req: imem_req=%b expected 1", imem_req);
    end
    a = addr_q.pop_front();
    tests++;
    if (imem_addr !== a) begin
      fails++; $display("FAIL fetch_addr: imem_addr=%h expected %h", imem_addr, a);
    end
    for (int i = 0; i < dly; i++) begin
      tick;
      tests++;
      if (imem_req !== 1'b1 || op_valid !== 1'b0 || imem_addr !== a) begin
        fails++; $display("FAIL fetch_hold: req=%b op_valid=%b addr=%h expected 1 0 %h",
                          imem_req, op_valid, imem_addr, a);
      end
    end
    imem_ack = 1'b1; imem_rdata = data;
    tick;
    imem_ack = 1'b0; imem_rdata = 24'($urandom);
    tests++;
    if (op_valid !== 1'b1 || state !== 3'd2) begin
      fails++; $display("FAIL exec_strobe: op_valid=%b state=%0d expected 1 2", op_valid, state);
    end
    o = op_q.pop_front();
    tests++;
    if (op !== o) begin
      fails++; $display("FAIL exec_op: op=%h expected %h", op, o);
    end
    last_exec = cyc;
    is_call = call; is_ret = ret; br_we = br; br_target = tgt; mem_busy = busy;
    exp_fault = 1'b0;
    if (call) begin
      if (m_sp == 5'd16) exp_fault = 1'b1;
      else begin m_stack[m_sp[3:0]] = m_pc + 8'd1; m_sp = m_sp + 5'd1; m_pc = tgt; end
    end else if (ret) begin
      if (m_sp == 5'd0) exp_fault = 1'b1;
      else begin m_sp = m_sp - 5'd1; m_pc = m_stack[m_sp[3:0]]; end
    end else if (br) m_pc = tgt;
    else m_pc = m_pc + 8'd1;
    exp_st = exp_fault ? 3'd5 : busy ? 3'd3 : hlt ? 3'd4 : 3'd1;
    tick;
    is_call = 1'b0; is_ret = 1'b0; br_we = 1'b0; br_target = '0;
    tests++;
    if (pc !== m_pc || sp !== m_sp) begin
      fails++; $display("FAIL next_pc: pc=%h sp=%0d expected %h %0d", pc, sp, m_pc, m_sp);
    end
    tests++;
    if (state !== exp_st || fault !== exp_fault) begin
      fails++; $display("FAIL exec_exit: state=%0d fault=%b expected %0d %b", state, fault, exp_st, exp_fault);
    end
    tests++;
    if (op_valid !== 1'b0 || op !== data) begin
      fails++; $display("FAIL op_hold: op_valid=%b op=%h expected 0 %h", op_valid, op, data);
    end
  endtask

  task automatic test_reset;
    do_reset;
    tests++;
    if (pc !== 8'h00 || sp !== 5'd0 || op !== 24'h0) begin
      fails++; $display("FAIL reset_regs: pc=%h sp=%0d op=%h expected 00 0 000000", pc, sp, op);
    end
    tests++;
    if (op_valid !== 1'b0 || imem_req !== 1'b0 || fault !== 1'b0 || state !== 3'd0) begin
      fails++; $display("FAIL reset_ctl: op_valid=%b req=%b fault=%b state=%0d expected 0 0 0 0",
                        op_valid, imem_req, fault, state);
    end
    tick; tick;
    tests++;
    if (state !== 3'd0 || imem_req !== 1'b0) begin
      fails++; $display("FAIL idle_quiet: state=%0d req=%b expected 0 0", state, imem_req);
    end
  endtask

  task automatic test_sequential;
    int prev;
    do_reset;
    go;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      run_instr(1, 24'h100000 + 24'(i), 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      if (i > 0) begin
        tests++;
        if (last_exec - prev != 3) begin
          fails++; $display("FAIL exec_period: %0d cycles expected 3", last_exec - prev);
        end
      end
      prev = last_exec;
    end
  endtask

  task automatic test_pc_wrap;
    do_reset;
    go;
    run_instr(0, 24'h200000, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    run_instr(0, 24'h200001, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tests++;
    if (pc !== 8'h00 || fault !== 1'b0) begin
      fails++; $display("FAIL pc_wrap: pc=%h fault=%b expected 00 0", pc, fault);
    end
  endtask

  task automatic test_call_ret;
    do_reset;
    go;
    run_instr(0, 24'h300000, 1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0);
    run_instr(0, 24'h300001, 1'b1, 1'b0, 1'b0, 8'h40, 1'b0, 1'b0);
    tests++;
    if (pc !== 8'h40 || sp !== 5'd1) begin
      fails++; $display("FAIL call: pc=%h sp=%0d expected 40 1", pc, sp);
    end
    run_instr(0, 24'h300002, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tests++;
    if (pc !== 8'h06 || sp !== 5'd0) begin
      fails++; $display("FAIL ret: pc=%h sp=%0d expected 06 0", pc, sp);
    end
  endtask

  task automatic test_stack_fault;
    do_reset;
    go;
    for (int i = 0; i < 16; i++)
      run_instr(0, 24'hC00000 + 24'(i), 1'b1, 1'b0, 1'b0, 8'h10 + 8'(i), 1'b0, 1'b0);
    run_instr(0, 24'hC000FF, 1'b1, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b0);
    tests++;
    if (fault !== 1'b1 || state !== 3'd5 || sp !== 5'd16) begin
      fails++; $display("FAIL overflow: fault=%b state=%0d sp=%0d expected 1 5 16", fault, state, sp);
    end
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      tests++;
      if (imem_req !== 1'b0 || state !== 3'd5 || op_valid !== 1'b0) begin
        fails++; $display("FAIL fault_sticky: req=%b state=%0d op_valid=%b expected 0 5 0",
                          imem_req, state, op_valid);
      end
    end
    start = 1'b0;
    do_reset;
    tests++;
    if (fault !== 1'b0 || state !== 3'd0) begin
      fails++; $display("FAIL fault_clear: fault=%b state=%0d expected 0 0", fault, state);
    end
    go;
    run_instr(0, 24'hD00000, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tests++;
    if (fault !== 1'b1 || pc !== 8'h00 || sp !== 5'd0) begin
      fails++; $display("FAIL underflow: fault=%b pc=%h sp=%0d expected 1 00 0", fault, pc, sp);
    end
  endtask

  task automatic test_mem_busy;
    do_reset;
    go;
    run_instr(0, 24'h500000, 1'b0, 1'b0, 1'b1, 8'h20, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick;
      tests++;
      if (state !== 3'd3 || imem_req !== 1'b0) begin
        fails++; $display("FAIL wait_hold: state=%0d req=%b expected 3 0", state, imem_req);
      end
    end
    mem_busy = 1'b0;
    tick;
    run_instr(0, 24'h500001, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_halt;
    do_reset;
    go;
    run_instr(0, 24'h600000, 1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
    run_instr(3, 24'h600001, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    halt_req = 1'b0;
    tick;
    tests++;
    if (state !== 3'd4 || imem_req !== 1'b0 || pc !== 8'h78) begin
      fails++; $display("FAIL halt_hold: state=%0d req=%b pc=%h expected 4 0 78", state, imem_req, pc);
    end
    start = 1'b1; halt_req = 1'b1;
    tick;
    tests++;
    if (state !== 3'd4) begin
      fails++; $display("FAIL halt_both: state=%0d expected 4", state);
    end
    halt_req = 1'b0;
    tick;
    start = 1'b0;
    run_instr(0, 24'h600002, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_fetch;
    do_reset;
    go;
    run_instr(0, 24'h700000, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
    tick;
    rst_n = 1'b0;
    tick;
    tests++;
    if (imem_req !== 1'b0 || state !== 3'd0 || pc !== 8'h00 || op !== 24'h0) begin
      fails++; $display("FAIL reset_mid_fetch: req=%b state=%0d pc=%h op=%h expected 0 0 00 000000",
                        imem_req, state, pc, op);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_pc_wrap;
    test_call_ret;
    test_stack_fault;
    test_mem_busy;
    test_halt;
    test_reset_mid_fetch;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
